// File: rtl/io_mux_pkg.sv
// Shared definitions for the IO pad multiplexer: APB geometry, register map
// offsets and the reset-default pad function.
package io_mux_pkg;

  localparam int APB_DW = 32;
  localparam int APB_AW = 10;

  localparam logic [APB_AW-1:0] SEL_BASE   = 10'h000;
  localparam logic [APB_AW-1:0] LOCK_OFS   = 10'h300;
  localparam logic [APB_AW-1:0] STATUS_OFS = 10'h304;

  // Function 0 is plain GPIO and is what every pad comes out of reset on.
  localparam int FUNC_GPIO = 0;

endpackage

// File: rtl/io_pad_mux_if.sv
// APB3 register port of the pad multiplexer. Signal names follow the AMBA
// naming used throughout the SoC.
interface io_pad_mux_if;
  import io_mux_pkg::*;

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [APB_AW-1:0] PADDR;
  logic [APB_DW-1:0] PWDATA;
  logic [APB_DW-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/io_pad_slice.sv
// One user IO pad: function select register with a switch-over guard gap,
// the combinational output mux and the pad input synchroniser.
module io_pad_slice
  import io_mux_pkg::*;
#(
  parameter int NUM_FUNC    = 4,
  parameter int SEL_W       = 2,
  parameter int GAP_CYCLES  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [SEL_W-1:0]    wr_sel,
  input  logic [NUM_FUNC-1:0] fn_out,
  input  logic [NUM_FUNC-1:0] fn_oeb,
  input  logic                pad_in,
  output logic                pad_out,
  output logic                pad_oeb,
  output logic                fn_in,
  output logic [SEL_W-1:0]    sel,
  output logic                busy
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  logic [GAP_W-1:0]       gap;
  logic [SYNC_STAGES-1:0] sync;

  // Select register; a real change (re)starts the guard gap, which then counts down.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= SEL_W'(FUNC_GPIO);
      gap <= '0;
    end else if (wr_en && (wr_sel != sel)) begin
      sel <= wr_sel;
      gap <= GAP_W'(GAP_CYCLES);
    end else if (gap != '0) begin
      gap <= gap - GAP_W'(1);
    end
  end

  // Input synchroniser shift chain; deliberately not gated by the gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pad_in};
    end
  end

  assign fn_in = sync[SYNC_STAGES-1];
  assign busy  = (gap != '0);

  // Zero-latency output mux; during the gap the pad is parked as an input driving 0.
  // NOTE: outputs take a value on every path first, so no latch is inferred.
  always_comb begin
    pad_out = fn_out[sel];
    pad_oeb = fn_oeb[sel];
    if (busy) begin
      pad_out = 1'b0;
      pad_oeb = 1'b1;
    end
  end

endmodule

// File: rtl/io_pad_mux.sv
// Run-time pin multiplexer between soc_core peripherals and the user IO pads.
// Holds APB decode, the sticky LOCK bit, STATUS and the read data mux; each
// pad's select, gap and synchroniser live in an io_pad_slice.
module io_pad_mux
  import io_mux_pkg::*;
#(
  parameter int NUM_PADS    = 38,
  parameter int NUM_FUNC    = 4,
  parameter int SEL_W       = 2,
  parameter int GAP_CYCLES  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  io_pad_mux_if.slave                  apb,
  input  logic [NUM_PADS*NUM_FUNC-1:0] fn_out,
  input  logic [NUM_PADS*NUM_FUNC-1:0] fn_oeb,
  output logic [NUM_PADS-1:0]          fn_in,
  input  logic [NUM_PADS-1:0]          pad_in,
  output logic [NUM_PADS-1:0]          pad_out,
  output logic [NUM_PADS-1:0]          pad_oeb
);

  logic              access;
  logic              wr_req;
  logic              wr_ok;
  logic              is_sel;
  logic              is_lock;
  logic              is_status;
  logic              bad_val;
  logic              err;
  logic              lock;
  logic [APB_AW-1:0] sel_ofs;
  logic [APB_AW-3:0] sel_idx;
  logic [SEL_W-1:0]  sel_rd [NUM_PADS];
  logic [NUM_PADS-1:0] busy;

  assign access    = apb.PSEL & apb.PENABLE;
  assign wr_req    = access & apb.PWRITE;
  assign sel_ofs   = apb.PADDR - SEL_BASE;
  assign sel_idx   = sel_ofs[APB_AW-1:2];
  assign is_sel    = (sel_ofs < APB_AW'(4 * NUM_PADS)) && (sel_ofs[1:0] == 2'b00);
  assign is_lock   = (apb.PADDR == LOCK_OFS);
  assign is_status = (apb.PADDR == STATUS_OFS);
  assign bad_val   = (apb.PWDATA >= APB_DW'(NUM_FUNC));

  // Any rejected access is reported and has no side effect.
  assign err = ~(is_sel | is_lock | is_status)
             | (apb.PWRITE & (is_status | (is_sel & bad_val) | ((is_sel | is_lock) & lock)));
  assign wr_ok = wr_req & ~err;

  assign apb.PSLVERR = access & err;
  assign apb.PREADY  = 1'b1;

  // Sticky lock: only a write of 1 sets it, only reset clears it.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      lock <= 1'b0;
    end else if (wr_ok && is_lock && apb.PWDATA[0]) begin
      lock <= 1'b1;
    end
  end

  // Read data is driven only during a read access phase, zero otherwise.
  always_comb begin
    apb.PRDATA = '0;
    if (access && !apb.PWRITE) begin
      if (is_sel) begin
        for (int p = 0; p < NUM_PADS; p++) begin
          if (sel_idx == (APB_AW-2)'(p)) begin
            apb.PRDATA[SEL_W-1:0] = sel_rd[p];
          end
        end
      end else if (is_lock) begin
        apb.PRDATA[0] = lock;
      end else if (is_status) begin
        apb.PRDATA[0] = |busy;
      end
    end
  end

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    io_pad_slice #(
      .NUM_FUNC    (NUM_FUNC),
      .SEL_W       (SEL_W),
      .GAP_CYCLES  (GAP_CYCLES),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_slice (
      .clk     (HCLK),
      .rst_n   (HRESETn),
      .wr_en   (wr_ok && is_sel && (sel_idx == (APB_AW-2)'(p))),
      .wr_sel  (apb.PWDATA[SEL_W-1:0]),
      .fn_out  (fn_out[p*NUM_FUNC +: NUM_FUNC]),
      .fn_oeb  (fn_oeb[p*NUM_FUNC +: NUM_FUNC]),
      .pad_in  (pad_in[p]),
      .pad_out (pad_out[p]),
      .pad_oeb (pad_oeb[p]),
      .fn_in   (fn_in[p]),
      .sel     (sel_rd[p]),
      .busy    (busy[p])
    );
  end

endmodule
